// File: rtl/pix_pkg.sv
// Shared pixel types and Sobel helpers for the gray-domain video stages.
package pix_pkg;

    typedef logic [7:0] gray_t;

    localparam logic signed [10:0] SOBEL_W_EDGE = 11'sd1;
    localparam logic signed [10:0] SOBEL_W_MID  = 11'sd2;

    function automatic gray_t sat8(logic [11:0] v);
        return (|v[11:8]) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic signed [10:0] px11(gray_t p);
        return $signed({3'b000, p});
    endfunction

endpackage

// File: rtl/line_buf.sv
// One line of pixel storage; the registered read returns the pre-write word.
module line_buf
    import pix_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int WIDTH = $bits(gray_t),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             pix_out_clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge pix_out_clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gray_sobel_edge.sv
// Streaming 3x3 Sobel edge detector on the gray pixel stream.
module gray_sobel_edge
    import pix_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int EDGE_THRESH = 128
) (
    input  logic       pix_out_clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_in_en,
    input  logic [7:0] pix_in_gray,
    output logic       edge_out_en,
    output logic [7:0] edge_out_mag,
    output logic       edge_out_bin,
    output logic       edge_out_eol,
    output logic       edge_out_eof
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam gray_t THRESH = gray_t'(EDGE_THRESH);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;

    logic          s1_vld_q;
    gray_t         s1_pix_q;
    logic [XW-1:0] s1_x_q;
    logic [YW-1:0] s1_y_q;
    gray_t         rd0, rd1;

    gray_t win_q [3][3];
    logic  s2_vld_q, s2_eol_q, s2_eof_q;

    logic  en_q, bin_q, eol_q, eof_q;
    gray_t mag_q;

    logic signed [10:0] gx, gy;
    logic [10:0] ax, ay;
    logic [11:0] mag12;
    gray_t       mag8;

    // frame_start forces this cycle's pixel (if any) to be (0,0)
    always_comb begin
        x_cur = frame_start ? '0 : x_q;
        y_cur = frame_start ? '0 : y_q;
        x_d = x_cur;
        y_d = y_cur;
        if (pix_in_en) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
            end
        end
    end

    line_buf #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .pix_out_clk(pix_out_clk),
        .we_i       (pix_in_en),
        .waddr_i    (x_cur),
        .wdata_i    (pix_in_gray),
        .re_i       (pix_in_en),
        .raddr_i    (x_cur),
        .rdata_o    (rd0)
    );

    // Row y-1 moves down one slot once its old word has been read out
    line_buf #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .pix_out_clk(pix_out_clk),
        .we_i       (s1_vld_q),
        .waddr_i    (s1_x_q),
        .wdata_i    (rd0),
        .re_i       (pix_in_en),
        .raddr_i    (x_cur),
        .rdata_o    (rd1)
    );

    always_comb begin
        gx = SOBEL_W_EDGE * px11(win_q[0][2])
           + SOBEL_W_MID  * px11(win_q[1][2])
           + SOBEL_W_EDGE * px11(win_q[2][2])
           - SOBEL_W_EDGE * px11(win_q[0][0])
           - SOBEL_W_MID  * px11(win_q[1][0])
           - SOBEL_W_EDGE * px11(win_q[2][0]);
        gy = SOBEL_W_EDGE * px11(win_q[2][0])
           + SOBEL_W_MID  * px11(win_q[2][1])
           + SOBEL_W_EDGE * px11(win_q[2][2])
           - SOBEL_W_EDGE * px11(win_q[0][0])
           - SOBEL_W_MID  * px11(win_q[0][1])
           - SOBEL_W_EDGE * px11(win_q[0][2]);
        ax = gx[10] ? 11'(-gx) : 11'(gx);
        ay = gy[10] ? 11'(-gy) : 11'(gy);
        mag12 = {1'b0, ax} + {1'b0, ay};
        mag8 = sat8(mag12);
    end

    always_ff @(posedge pix_out_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= '0;
            y_q      <= '0;
            s1_vld_q <= 1'b0;
            s1_pix_q <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_eol_q <= 1'b0;
            s2_eof_q <= 1'b0;
            en_q     <= 1'b0;
            mag_q    <= '0;
            bin_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            s1_vld_q <= pix_in_en;
            if (pix_in_en) begin
                s1_pix_q <= pix_in_gray;
                s1_x_q   <= x_cur;
                s1_y_q   <= y_cur;
            end
            s2_vld_q <= s1_vld_q && (s1_x_q >= XW'(2)) && (s1_y_q >= YW'(2));
            if (s1_vld_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= rd1;
                win_q[1][2] <= rd0;
                win_q[2][2] <= s1_pix_q;
                s2_eol_q <= (s1_x_q == X_LAST);
                s2_eof_q <= (s1_x_q == X_LAST) && (s1_y_q == Y_LAST);
            end
            en_q <= s2_vld_q;
            if (s2_vld_q) begin
                mag_q <= mag8;
                bin_q <= (mag8 >= THRESH);
                eol_q <= s2_eol_q;
                eof_q <= s2_eof_q;
            end
        end
    end

    assign edge_out_en  = en_q;
    assign edge_out_mag = mag_q;
    assign edge_out_bin = bin_q;
    assign edge_out_eol = eol_q;
    assign edge_out_eof = eof_q;

endmodule

// File: tb/tb_gray_sobel_edge.sv
// Bench for gray_sobel_edge: kernel-level image model against captured outputs.
module tb_gray_sobel_edge;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int TH = 128;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       pix_in_en = 1'b0;
    logic [7:0] pix_in_gray = 8'd0;
    logic       edge_out_en;
    logic [7:0] edge_out_mag;
    logic       edge_out_bin;
    logic       edge_out_eol;
    logic       edge_out_eof;

    typedef struct packed {
        logic [7:0] mag;
        logic       bin;
        logic       eol;
        logic       eof;
        int         cyc;
    } obs_t;

    obs_t       cap_q[$];
    obs_t       exp_q[$];
    logic [7:0] img [H][W];
    int         acc [H][W];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    gray_sobel_edge #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .EDGE_THRESH(TH)
    ) dut (
        .pix_out_clk (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_in_en   (pix_in_en),
        .pix_in_gray (pix_in_gray),
        .edge_out_en (edge_out_en),
        .edge_out_mag(edge_out_mag),
        .edge_out_bin(edge_out_bin),
        .edge_out_eol(edge_out_eol),
        .edge_out_eof(edge_out_eof)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst_n && edge_out_en)
            cap_q.push_back(obs_t'{mag: edge_out_mag, bin: edge_out_bin,
                                   eol: edge_out_eol, eof: edge_out_eof, cyc: cyc});

    // Drive one frame from img; gap<0 means random 0..2 idle cycles per pixel
    task automatic play_frame(input int gap, input bit fs);
        int g, gx, gy, p, m;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                @(negedge clk);
                pix_in_en   = 1'b1;
                pix_in_gray = img[y][x];
                frame_start = fs && (x == 0) && (y == 0);
                acc[y][x]   = cyc;
                g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
                repeat (g) begin
                    @(negedge clk);
                    pix_in_en   = 1'b0;
                    frame_start = 1'b0;
                    pix_in_gray = 8'($urandom);
                end
            end
        for (int y = 2; y < H; y++)
            for (int x = 2; x < W; x++) begin
                gx = 0;
                gy = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) begin
                        p  = int'(img[y-2+r][x-2+c]);
                        gx += (c - 1) * ((r == 1) ? 2 : 1) * p;
                        gy += (r - 1) * ((c == 1) ? 2 : 1) * p;
                    end
                m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (m > 255) m = 255;
                exp_q.push_back(obs_t'{mag: 8'(m), bin: (m >= TH),
                                       eol: (x == W-1), eof: (x == W-1 && y == H-1),
                                       cyc: acc[y][x] + 3});
            end
    endtask

    task automatic drain();
        repeat (6) begin
            @(negedge clk);
            pix_in_en   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({edge_out_en, edge_out_mag, edge_out_bin, edge_out_eol, edge_out_eof} !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h exp 000",
                     {edge_out_en, edge_out_mag, edge_out_bin, edge_out_eol, edge_out_eof});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (edge_out_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_en got %b exp 0", edge_out_en);
        end
    endtask

    task automatic test_flat();
        cap_q.delete();
        exp_q.delete();
        foreach (img[y, x]) img[y][x] = 8'd100;
        play_frame(0, 1'b1);
        drain();
        tests++;
        if (cap_q.size() != 24) begin
            fails++;
            $display("FAIL flat_count got %0d exp 24", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL flat_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_vstep();
        int hot;
        cap_q.delete();
        exp_q.delete();
        foreach (img[y, x]) img[y][x] = (x >= 4) ? 8'd200 : 8'd0;
        play_frame(0, 1'b0);
        drain();
        tests++;
        if (cap_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL vstep_count got %0d exp %0d", cap_q.size(), exp_q.size());
        end
        hot = 0;
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL vstep_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
            if (cap_q[i].mag == 8'd255 && cap_q[i].bin) hot++;
        end
        tests++;
        if (hot != 8) begin
            fails++;
            $display("FAIL vstep_saturated got %0d exp 8", hot);
        end
    endtask

    task automatic test_ramp();
        cap_q.delete();
        exp_q.delete();
        foreach (img[y, x]) img[y][x] = 8'(10 * x);
        play_frame(0, 1'b1);
        drain();
        tests++;
        if (cap_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL ramp_count got %0d exp %0d", cap_q.size(), exp_q.size());
        end
        foreach (cap_q[i]) begin
            tests++;
            if (cap_q[i].mag !== 8'd80 || cap_q[i].bin !== 1'b0) begin
                fails++;
                $display("FAIL ramp_mag[%0d] got %0d/%b exp 80/0", i, cap_q[i].mag, cap_q[i].bin);
            end
        end
    endtask

    task automatic test_gapped();
        cap_q.delete();
        exp_q.delete();
        foreach (img[y, x]) img[y][x] = 8'd100;
        play_frame(2, 1'b1);
        drain();
        tests++;
        if (cap_q.size() != 24) begin
            fails++;
            $display("FAIL gapped_count got %0d exp 24", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL gapped_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_realign();
        cap_q.delete();
        exp_q.delete();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            pix_in_en   = 1'b1;
            pix_in_gray = 8'($urandom);
        end
        @(negedge clk);
        pix_in_en   = 1'b0;
        frame_start = 1'b1;
        foreach (img[y, x]) img[y][x] = 8'($urandom);
        play_frame(0, 1'b0);
        drain();
        tests++;
        if (cap_q.size() != 24) begin
            fails++;
            $display("FAIL realign_count got %0d exp 24", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL realign_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        cap_q.delete();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            foreach (img[y, x]) img[y][x] = 8'($urandom);
            play_frame(0, 1'b1);
        end
        drain();
        tests++;
        if (cap_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL b2b_count got %0d exp %0d", cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL b2b_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        cap_q.delete();
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            foreach (img[y, x]) img[y][x] = ($urandom_range(1, 0) != 0) ? 8'($urandom) : 8'($urandom_range(40, 0));
            play_frame(-1, 1'b1);
        end
        drain();
        tests++;
        if (cap_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count got %0d exp %0d", cap_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL rand_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        foreach (img[y, x]) img[y][x] = (x >= 4) ? 8'd200 : 8'd0;
        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            pix_in_en   = 1'b1;
            pix_in_gray = img[i / W][i % W];
        end
        repeat (3) begin
            @(negedge clk);
            pix_in_en = 1'b0;
        end
        tests++;
        if (edge_out_mag !== 8'd255 || edge_out_bin !== 1'b1) begin
            fails++;
            $display("FAIL midrst_before got %0d/%b exp 255/1", edge_out_mag, edge_out_bin);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({edge_out_en, edge_out_mag, edge_out_bin, edge_out_eol, edge_out_eof} !== 12'd0) begin
            fails++;
            $display("FAIL midrst_outputs got %h exp 000",
                     {edge_out_en, edge_out_mag, edge_out_bin, edge_out_eol, edge_out_eof});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cap_q.delete();
        exp_q.delete();
        foreach (img[y, x]) img[y][x] = 8'd100;
        play_frame(0, 1'b0);
        drain();
        tests++;
        if (cap_q.size() != 24) begin
            fails++;
            $display("FAIL midrst_count got %0d exp 24", cap_q.size());
        end
        foreach (exp_q[i]) if (i < cap_q.size()) begin
            tests++;
            if (cap_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL midrst_out[%0d] got %h exp %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vstep();
        test_ramp();
        test_gapped();
        test_realign();
        test_back_to_back();
        test_random_gaps();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
